instr_fetch: RTL and testbench

Instruction-fetch (IF) stage of the pipelined RV32I core. It sits directly upstream of instr_mem.
- Owns the program counter and drives the memory word address.
- Captures the combinationally returned instruction into the IF/ID pipeline register.
- Applies stall, flush and branch/jump redirect requests from the hazard unit and the EX stage.
- Halts on a misaligned redirect target and counts delivered instructions.

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and registers the returned instruction into the IF/ID pipeline register.
// Redirects from EX win over hazard-unit stall/flush. A misaligned redirect
// target parks the stage in HALT until reset.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal fetch; PC advances, stalls, flushes or redirects
//   HALT  | misaligned redirect seen; PC frozen, IF/ID holds a bubble
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] instr_nxt;
  logic [31:0] id_pc_nxt;
  logic [31:0] id_pc_plus4_nxt;
  logic        valid_nxt;
  logic        err_nxt;
  logic [31:0] count_nxt;
  logic        target_misaligned;

  assign imem_addr         = pc;
  assign pc_plus4          = pc + 32'd4;
  assign target_misaligned = (redirect_target[1:0] != 2'b00);

  // State, PC and IF/ID register update; reset overrides all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 32'h0000_0000;
      if_id_pc_plus4 <= 32'h0000_0000;
      if_id_valid    <= 1'b0;
      misalign_err   <= 1'b0;
      fetch_count    <= 32'h0000_0000;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_id_instr    <= instr_nxt;
      if_id_pc       <= id_pc_nxt;
      if_id_pc_plus4 <= id_pc_plus4_nxt;
      if_id_valid    <= valid_nxt;
      misalign_err   <= err_nxt;
      fetch_count    <= count_nxt;
    end
  end

  // Next-state and datapath selection; everything holds unless a rule fires.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = if_id_instr;
    id_pc_nxt       = if_id_pc;
    id_pc_plus4_nxt = if_id_pc_plus4;
    valid_nxt       = if_id_valid;
    err_nxt         = misalign_err;
    count_nxt       = fetch_count;

    case (state)
      RUN: begin
        if (redirect_valid) begin
          // The word fetched this cycle is wrong-path, so IF/ID gets a bubble.
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
          if (target_misaligned) begin
            state_nxt = HALT;
            err_nxt   = 1'b1;
            // Keep imem_addr word-aligned even while halted.
            pc_nxt    = redirect_target & ~32'd3;
          end else begin
            pc_nxt    = redirect_target;
          end
        end else if (flush) begin
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
          if (!stall) begin
            pc_nxt = pc_plus4;
          end
        end else if (!stall) begin
          instr_nxt       = imem_rdata;
          id_pc_nxt       = pc;
          id_pc_plus4_nxt = pc_plus4;
          valid_nxt       = 1'b1;
          pc_nxt          = pc_plus4;
          count_nxt       = fetch_count + 32'd1;
        end
      end
      HALT: begin
        instr_nxt = NOP_INSTR;
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed walk through the fetch scenarios followed by
// randomized stall/flush/redirect/reset traffic, all checked against a
// behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic        m_valid, m_err, m_halt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];

  instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the fetch rules, evaluated on the pre-edge model state.
  task automatic model_step(input logic r, input logic rv, input logic [31:0] rt,
                            input logic st, input logic fl);
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_valid = 1'b0; m_err = 1'b0; m_cnt = 32'h0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (rv) begin
        m_instr = NOP; m_valid = 1'b0;
        if (rt % 4 != 0) begin
          m_halt = 1'b1; m_err = 1'b1; m_pc = rt - (rt % 4);
        end else begin
          m_pc = rt;
        end
      end else if (fl) begin
        m_instr = NOP; m_valid = 1'b0;
        if (!st) m_pc = m_pc + 4;
      end else if (!st) begin
        m_instr = mem[(m_pc / 4) % 256];
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 4;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
        m_cnt   = m_cnt + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("imem_addr",      imem_addr,           m_pc);
    chk("if_id_instr",    if_id_instr,         m_instr);
    chk("if_id_pc",       if_id_pc,            m_ipc);
    chk("if_id_pc_plus4", if_id_pc_plus4,      m_ipc4);
    chk("if_id_valid",    {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("misalign_err",   {31'b0, misalign_err}, {31'b0, m_err});
    chk("fetch_count",    fetch_count,         m_cnt);
  endtask

  // Drive inputs just after a falling edge, take the rising edge, check on the next falling edge.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rt,
                       input logic st, input logic fl);
    rst = r; redirect_valid = rv; redirect_target = rt; stall = st; flush = fl;
    @(posedge clk);
    model_step(r, rv, rt, st, fl);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic        r, rv, st, fl;
    logic [31:0] rt, rnd;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0020_c463;
    mem[3] = 32'h0030_0193;
    mem[4] = 32'h0040_0213;

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    m_halt = 1'b0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_addr",  imem_addr,   32'h0);
    chk("rst_instr", if_id_instr, NOP);

    // Free-running fetch
    cycle(0, 0, 0, 0, 0);
    chk("tp_if1_instr", if_id_instr, 32'h0010_0093);
    chk("tp_if1_pc",    if_id_pc,    32'h0);
    cycle(0, 0, 0, 0, 0);
    chk("tp_if2_instr", if_id_instr, 32'h0020_0113);
    chk("tp_addr8",     imem_addr,   32'h8);

    // Two-cycle stall holding (00200113, 4)
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("tp_stall_addr",  imem_addr,   32'h8);
    chk("tp_stall_instr", if_id_instr, 32'h0020_0113);
    chk("tp_stall_cnt",   fetch_count, 32'd2);
    cycle(0, 0, 0, 0, 0);
    chk("tp_rel_instr", if_id_instr, 32'h0020_c463);
    chk("tp_rel_pc",    if_id_pc,    32'h8);
    chk("tp_rel_cnt",   fetch_count, 32'd3);

    // Redirect from 0xC to 0x10
    cycle(0, 1, 32'h10, 0, 0);
    chk("tp_rd_addr",  imem_addr,   32'h10);
    chk("tp_rd_valid", {31'b0, if_id_valid}, 32'h0);
    cycle(0, 0, 0, 0, 0);
    chk("tp_rd_instr", if_id_instr, 32'h0040_0213);
    chk("tp_rd_pc",    if_id_pc,    32'h10);

    // Redirect beats stall+flush
    cycle(0, 1, 32'h20, 1, 1);
    chk("tp_all_addr", imem_addr, 32'h20);

    // Flush+stall holds PC at 0x8
    cycle(0, 1, 32'h8, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h8, 0, 0);
    cycle(0, 0, 0, 1, 1);
    chk("tp_fs_addr",  imem_addr, 32'h8);
    chk("tp_fs_valid", {31'b0, if_id_valid}, 32'h0);

    // Misaligned target halts; later redirect ignored
    cycle(0, 1, 32'h22, 0, 0);
    chk("tp_mis_err",  {31'b0, misalign_err}, 32'h1);
    chk("tp_mis_addr", imem_addr, 32'h20);
    cycle(0, 1, 32'h40, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    chk("tp_halt_addr",  imem_addr, 32'h20);
    chk("tp_halt_valid", {31'b0, if_id_valid}, 32'h0);
    cycle(1, 0, 0, 0, 0);
    chk("tp_rst_addr", imem_addr, 32'h0);
    chk("tp_rst_err",  {31'b0, misalign_err}, 32'h0);

    // PC wrap past the top of the address space
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr,      32'h0);
    chk("wrap_pc4",  if_id_pc_plus4, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      rv = ($urandom_range(0, 99) < 12);
      st = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 10);
      rnd = $urandom;
      if ($urandom_range(0, 9) == 0) rt = rnd;
      else rt = {rnd[31:2], 2'b00};
      cycle(r, rv, rt, st, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
